// File: rtl/seg_dec_pkg.sv
// ============================================================================
// seg_dec_pkg : shared types and segment encodings for seg_pattern_decoder
// Rev 1.0
// ============================================================================
`default_nettype none

package seg_dec_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    NUMERIC = 2'd0,
    MARKER  = 2'd1,
    ILLEGAL = 2'd2
  } pat_class_e;

  // Bit 7 is the sign/dot segment; negative values light it.
  localparam logic [7:0] SEG_NEG4   = 8'b11100110;
  localparam logic [7:0] SEG_NEG3   = 8'b11001111;
  localparam logic [7:0] SEG_NEG2   = 8'b11011011;
  localparam logic [7:0] SEG_NEG1   = 8'b10000110;
  localparam logic [7:0] SEG_POS0   = 8'b00111111;
  localparam logic [7:0] SEG_POS1   = 8'b00000110;
  localparam logic [7:0] SEG_POS2   = 8'b01011011;
  localparam logic [7:0] SEG_POS3   = 8'b01001111;
  localparam logic [7:0] SEG_MARKER = 8'b10000000;

endpackage

`default_nettype wire

// File: rtl/seg_pattern_lut.sv
// ============================================================================
// seg_pattern_lut : combinational classifier/decoder for one 8-bit pattern
// Rev 1.0
// ============================================================================
`default_nettype none

module seg_pattern_lut
  import seg_dec_pkg::*;
(
  input  logic [7:0] pattern_i,
  output logic [1:0] class_o,
  output logic [2:0] value_o
);

  always_comb begin
    class_o = NUMERIC;
    value_o = 3'b000;
    case (pattern_i)
      SEG_NEG4:   value_o = 3'b100;
      SEG_NEG3:   value_o = 3'b101;
      SEG_NEG2:   value_o = 3'b110;
      SEG_NEG1:   value_o = 3'b111;
      SEG_POS0:   value_o = 3'b000;
      SEG_POS1:   value_o = 3'b001;
      SEG_POS2:   value_o = 3'b010;
      SEG_POS3:   value_o = 3'b011;
      SEG_MARKER: class_o = MARKER;
      default:    class_o = ILLEGAL;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seg_pattern_decoder.sv
// ============================================================================
// seg_pattern_decoder : stability-qualified seven-segment bus decoder
// Optional: define SEG_DEC_STICKY_ERR_EN to add err_sticky_o
// Rev 1.0
// ============================================================================
`default_nettype none

module seg_pattern_decoder
  import seg_dec_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_CNT_W     = 8
) (
  input  logic                 clk_2,
  input  logic                 rst_n,
  input  logic [7:0]           seg_in,
  input  logic                 sample_en,
  input  logic                 clr_err_i,
  output logic [2:0]           value_o,
  output logic                 value_valid_o,
  output logic                 dot_only_o,
  output logic                 update_o,
  output logic                 err_o,
`ifdef SEG_DEC_STICKY_ERR_EN
  output logic                 err_sticky_o,
`endif
  output logic [ERR_CNT_W-1:0] err_count_o
);

  localparam int              CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TGT = CNT_W'(STABLE_CYCLES);

  state_e               state_q, state_d;
  logic [7:0]           cand_q, cand_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 acc_q, acc_d;
  logic [7:0]           acc_pat_q, acc_pat_d;
  logic [2:0]           value_q, value_d;
  logic                 valid_q, valid_d;
  logic                 dot_q, dot_d;
  logic                 update_q, update_d;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [1:0]           lut_class;
  logic [2:0]           lut_value;
  logic                 illegal_acc;

  seg_pattern_lut u_lut (
    .pattern_i (acc_pat_q),
    .class_o   (lut_class),
    .value_o   (lut_value)
  );

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    acc_d     = 1'b0;
    acc_pat_d = acc_pat_q;
    case (state_q)
      IDLE: begin
        if (sample_en) begin
          cand_d  = seg_in;
          cnt_d   = CNT_ONE;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (sample_en) begin
          if (seg_in == cand_q) begin
            cnt_d = cnt_q + CNT_ONE;
          end else begin
            cand_d = seg_in;
            cnt_d  = CNT_ONE;
          end
        end
      end
      LOCKED: begin
        if (sample_en && (seg_in != cand_q)) begin
          cand_d  = seg_in;
          cnt_d   = CNT_ONE;
          state_d = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A fresh capture can complete immediately when only one sample is required.
    if ((state_d == SETTLE) && (cnt_d == CNT_TGT)) begin
      state_d   = LOCKED;
      acc_d     = 1'b1;
      acc_pat_d = cand_d;
    end
  end

  assign illegal_acc = acc_q && (lut_class == ILLEGAL);

  always_comb begin
    value_d   = value_q;
    valid_d   = valid_q;
    dot_d     = dot_q;
    update_d  = 1'b0;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    if (acc_q) begin
      case (lut_class)
        NUMERIC: begin
          update_d = !valid_q || (lut_value != value_q);
          value_d  = lut_value;
          valid_d  = 1'b1;
          dot_d    = 1'b0;
        end
        MARKER: begin
          dot_d   = 1'b1;
          valid_d = 1'b0;
        end
        default: begin
          err_d = 1'b1;
          if (err_cnt_q != {ERR_CNT_W{1'b1}}) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
      endcase
    end
    if (clr_err_i) err_cnt_d = '0;
  end

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cand_q    <= 8'h00;
      cnt_q     <= '0;
      acc_q     <= 1'b0;
      acc_pat_q <= 8'h00;
      value_q   <= 3'b000;
      valid_q   <= 1'b0;
      dot_q     <= 1'b0;
      update_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      acc_pat_q <= acc_pat_d;
      value_q   <= value_d;
      valid_q   <= valid_d;
      dot_q     <= dot_d;
      update_q  <= update_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

`ifdef SEG_DEC_STICKY_ERR_EN
  logic sticky_q, sticky_d;

  always_comb begin
    sticky_d = sticky_q | illegal_acc;
    if (clr_err_i) sticky_d = 1'b0;
  end

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) sticky_q <= 1'b0;
    else        sticky_q <= sticky_d;
  end

  assign err_sticky_o = sticky_q;
`else
  logic unused_illegal_acc;
  assign unused_illegal_acc = illegal_acc;
`endif

  assign value_o       = value_q;
  assign value_valid_o = valid_q;
  assign dot_only_o    = dot_q;
  assign update_o      = update_q;
  assign err_o         = err_q;
  assign err_count_o   = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_pattern_decoder.sv
// ============================================================================
// tb_seg_pattern_decoder : self-checking bench for seg_pattern_decoder
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_seg_pattern_decoder;
  import seg_dec_pkg::*;

  localparam int S  = 4;
  localparam int EW = 8;

  logic          clk_2 = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    seg_in = 8'h00;
  logic          sample_en = 1'b0;
  logic          clr_err_i = 1'b0;
  logic [2:0]    value_o;
  logic          value_valid_o;
  logic          dot_only_o;
  logic          update_o;
  logic          err_o;
  logic [EW-1:0] err_count_o;
`ifdef SEG_DEC_STICKY_ERR_EN
  logic          err_sticky_o;
`endif

  logic [7:0] lut_pat = 8'h00;
  logic [1:0] lut_cls;
  logic [2:0] lut_val;

  always #5 clk_2 = ~clk_2;

  seg_pattern_decoder #(.STABLE_CYCLES(S), .ERR_CNT_W(EW)) dut (
    .clk_2         (clk_2),
    .rst_n         (rst_n),
    .seg_in        (seg_in),
    .sample_en     (sample_en),
    .clr_err_i     (clr_err_i),
    .value_o       (value_o),
    .value_valid_o (value_valid_o),
    .dot_only_o    (dot_only_o),
    .update_o      (update_o),
    .err_o         (err_o),
`ifdef SEG_DEC_STICKY_ERR_EN
    .err_sticky_o  (err_sticky_o),
`endif
    .err_count_o   (err_count_o)
  );

  seg_pattern_lut u_bench_lut (
    .pattern_i (lut_pat),
    .class_o   (lut_cls),
    .value_o   (lut_val)
  );

  typedef struct {
    logic [7:0] pat;
    logic [1:0] cls;
    logic [2:0] val;
  } vec_t;

  typedef struct {
    logic [2:0]    value;
    logic          valid;
    logic          dot;
    logic          upd;
    logic          err;
    logic [EW-1:0] cnt;
    logic          sticky;
  } exp_t;

  int checks = 0;
  int errors = 0;
  int upd_seen = 0;
  int err_seen = 0;

  exp_t sb[$];

  // Reference model state
  logic [2:0]    m_value;
  logic          m_valid, m_dot, m_sticky;
  logic [EW-1:0] m_cnt;
  logic [7:0]    m_cand;
  logic          m_have, m_locked, pend;
  logic [7:0]    pend_pat;
  int            m_run;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void ref_decode(input logic [7:0] p, output logic [1:0] cls, output logic [2:0] val);
    cls = NUMERIC;
    val = 3'b000;
    case (p)
      8'b11100110: val = 3'b100;
      8'b11001111: val = 3'b101;
      8'b11011011: val = 3'b110;
      8'b10000110: val = 3'b111;
      8'b00111111: val = 3'b000;
      8'b00000110: val = 3'b001;
      8'b01011011: val = 3'b010;
      8'b01001111: val = 3'b011;
      8'b10000000: cls = MARKER;
      default:     cls = ILLEGAL;
    endcase
  endfunction

  function automatic logic [15:0] outs();
`ifdef SEG_DEC_STICKY_ERR_EN
    return {err_sticky_o, value_o, value_valid_o, dot_only_o, update_o, err_o, err_count_o};
`else
    return {1'b0, value_o, value_valid_o, dot_only_o, update_o, err_o, err_count_o};
`endif
  endfunction

  function automatic logic [15:0] exp_outs(input exp_t e);
`ifdef SEG_DEC_STICKY_ERR_EN
    return {e.sticky, e.value, e.valid, e.dot, e.upd, e.err, e.cnt};
`else
    return {1'b0, e.value, e.valid, e.dot, e.upd, e.err, e.cnt};
`endif
  endfunction

  task automatic model_reset();
    m_value = 3'b000; m_valid = 1'b0; m_dot = 1'b0; m_sticky = 1'b0; m_cnt = '0;
    m_cand = 8'h00; m_have = 1'b0; m_locked = 1'b0; pend = 1'b0; pend_pat = 8'h00; m_run = 0;
    sb.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; seg_in = 8'h00; sample_en = 1'b0; clr_err_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_2);
    #1;
    check("reset_outputs", outs(), 16'h0000);
    rst_n = 1'b1;
  endtask

  // One clock: drive, predict the outputs after the edge, then compare.
  task automatic cyc(input logic [7:0] pat, input logic en, input logic clr);
    exp_t e;
    logic [1:0] cls;
    logic [2:0] val;
    seg_in = pat; sample_en = en; clr_err_i = clr;
    e.upd = 1'b0;
    e.err = 1'b0;
    if (pend) begin
      ref_decode(pend_pat, cls, val);
      if (cls == NUMERIC) begin
        e.upd = !m_valid || (val != m_value);
        m_value = val; m_valid = 1'b1; m_dot = 1'b0;
      end else if (cls == MARKER) begin
        m_dot = 1'b1; m_valid = 1'b0;
      end else begin
        e.err = 1'b1; m_sticky = 1'b1;
        if (m_cnt != {EW{1'b1}}) m_cnt = m_cnt + 1'b1;
      end
    end
    if (clr) begin m_cnt = '0; m_sticky = 1'b0; end
    e.value = m_value; e.valid = m_valid; e.dot = m_dot; e.cnt = m_cnt; e.sticky = m_sticky;
    sb.push_back(e);
    pend = 1'b0;
    if (en) begin
      if (m_have && pat == m_cand) begin
        if (!m_locked) m_run++;
      end else begin
        m_cand = pat; m_have = 1'b1; m_run = 1; m_locked = 1'b0;
      end
      if (!m_locked && m_run == S) begin
        m_locked = 1'b1; pend = 1'b1; pend_pat = pat;
      end
    end
    @(posedge clk_2);
    #1;
    e = sb.pop_front();
    check("scoreboard_outputs", outs(), exp_outs(e));
    upd_seen += int'(update_o);
    err_seen += int'(err_o);
  endtask

  task automatic hold(input logic [7:0] pat, input int n);
    for (int k = 0; k < n; k++) cyc(pat, 1'b1, 1'b0);
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{8'b00111111, NUMERIC, 3'b000};
    vecs[1] = '{8'b00000110, NUMERIC, 3'b001};
    vecs[2] = '{8'b01011011, NUMERIC, 3'b010};
    vecs[3] = '{8'b01001111, NUMERIC, 3'b011};
    vecs[4] = '{8'b11100110, NUMERIC, 3'b100};
    vecs[5] = '{8'b11001111, NUMERIC, 3'b101};
    vecs[6] = '{8'b11011011, NUMERIC, 3'b110};
    vecs[7] = '{8'b10000110, NUMERIC, 3'b111};
    vecs[8] = '{8'b10000000, MARKER,  3'b000};
    vecs[9] = '{8'b11111111, ILLEGAL, 3'b000};

    do_reset();

    // Table: classifier plus end-to-end decode of every legal pattern
    for (int i = 0; i < 10; i++) begin
      lut_pat = vecs[i].pat;
      #1;
      check("lut_class", lut_cls, vecs[i].cls);
      if (vecs[i].cls == NUMERIC) check("lut_value", lut_val, vecs[i].val);
      hold(vecs[i].pat, S + 1);
      if (vecs[i].cls == NUMERIC) begin
        check("table_value", value_o, vecs[i].val);
        check("table_valid", value_valid_o, 1'b1);
      end else if (vecs[i].cls == MARKER) begin
        check("table_dot", {dot_only_o, value_valid_o}, 2'b10);
      end else begin
        check("table_errcnt", err_count_o, 8'd1);
      end
    end

    // 1: latency of first acceptance
    do_reset();
    upd_seen = 0;
    hold(8'b00111111, S);
    check("t1_not_yet_valid", value_valid_o, 1'b0);
    hold(8'b00111111, 1);
    check("t1_valid_value_upd", {value_valid_o, value_o, update_o}, 5'b1_000_1);
    hold(8'b00111111, 3);
    check("t1_single_update", upd_seen, 1);

    // 2: glitch rejection and silent re-acceptance
    upd_seen = 0;
    hold(8'b01001111, 3);
    hold(8'b00000110, S + 1);
    check("t2_value1", value_o, 3'b001);
    check("t2_one_update", upd_seen, 1);
    upd_seen = 0;
    hold(8'b11011011, 2);
    hold(8'b00000110, S + 2);
    check("t2_no_update_on_return", upd_seen, 0);
    check("t2_value_kept", value_o, 3'b001);

    // 3: negatives
    upd_seen = 0;
    hold(8'b10000110, S + 1);
    check("t3_minus1", value_o, 3'b111);
    hold(8'b11100110, S + 1);
    check("t3_minus4", value_o, 3'b100);
    check("t3_updates", upd_seen, 2);

    // 4: marker after value 2
    hold(8'b01011011, S + 1);
    hold(8'b10000000, S + 1);
    check("t4_marker", {dot_only_o, value_valid_o, value_o}, 5'b1_0_010);

    // 5: illegal patterns, saturation and clear priority
    err_seen = 0;
    hold(8'b11111111, S + 1);
    check("t5_err_once", err_seen, 1);
    check("t5_count1", err_count_o, 8'd1);
    for (int i = 0; i < 299; i++) hold((i % 2 == 0) ? 8'h00 : 8'hFF, S);
    hold(8'h00, 1);
    check("t5_saturated", err_count_o, 8'd255);
    hold(8'hFF, S);
    cyc(8'hFF, 1'b1, 1'b1);
    check("t5_clr_vs_acc", {err_o, err_count_o}, 9'h100);
    cyc(8'hFF, 1'b1, 1'b0);
    check("t5_err_dropped", err_o, 1'b0);

    // 6: sample_en gap mid-settle, then async reset mid-settle
    hold(8'b01011011, 2);
    for (int i = 0; i < 5; i++) cyc(8'($urandom_range(0, 255)), 1'b0, 1'b0);
    hold(8'b01011011, 1);
    check("t6_still_settling", value_valid_o, 1'b0);
    hold(8'b01011011, 2);
    check("t6_resumed", {value_valid_o, value_o}, 4'b1_010);
    hold(8'b00000110, 2);
    rst_n = 1'b0;
    #1;
    check("t6_async_reset", outs(), 16'h0000);
    do_reset();
    hold(8'b00000110, S + 1);
    check("t6_after_reset", {value_valid_o, value_o}, 4'b1_001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
